// File: rtl/mc_arb_pkg.sv
// Shared types and helpers for the multicast lock arbiter.
package mc_arb_pkg;

    localparam int MAX_PORTS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } in_state_e;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mc_rr_pick.sv
// N-way round-robin picker: one-hot grant of the first request at or after ptr.
module mc_rr_pick
    import mc_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [N-1:0] upper;
    logic [N-1:0] pool;

    // Requests at or above ptr take precedence; otherwise wrap to the lowest index.
    always_comb begin
        logic found;
        upper = '0;
        for (int unsigned i = 0; i < N; i++) begin
            upper[i] = req[i] && (i >= 32'(ptr));
        end
        pool  = (|upper) ? upper : req;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && pool[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_lock_arbiter.sv
// All-or-nothing multicast crossbar arbiter with per-output locking for multi-beat transfers.
// Optional starvation guard enabled by defining MC_ARB_AGE_EN.
module mc_lock_arbiter
    import mc_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int LEN_W     = 8,
    parameter int AGE_MAX   = 15,
    localparam int SEL_W    = sel_w(NUM_PORTS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_dst,
    input  logic [NUM_PORTS*LEN_W-1:0]     req_len,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS-1:0]           in_beat,
    output logic [NUM_PORTS-1:0]           in_busy,
    output logic [NUM_PORTS*SEL_W-1:0]     out_sel,
    output logic [NUM_PORTS-1:0]           out_active,
    output logic                           err_zero_dst
);

    localparam int N = NUM_PORTS;
    localparam bit CFG_OK = (N >= 2) && (N <= MAX_PORTS) && (LEN_W >= 1) && (AGE_MAX >= 1);

    if (!CFG_OK) begin : g_bad_config
    end

    in_state_e        state_q [N];
    in_state_e        state_d [N];
    logic [LEN_W-1:0] cnt_q   [N];
    logic [LEN_W-1:0] cnt_d   [N];
    logic [SEL_W-1:0] owner_q [N];
    logic [SEL_W-1:0] owner_d [N];
    logic [SEL_W-1:0] ptr_q   [N];
    logic [SEL_W-1:0] ptr_d   [N];
    logic [N-1:0]     lock_q, lock_d;
    logic             err_q, err_d;

    logic [N-1:0] dst      [N];
    logic [N-1:0] comp_req [N];
    logic [N-1:0] win      [N];
    logic [N-1:0] cand, fin, hs, rsv, urg_oh;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            dst[i]  = req_dst[i*N +: N];
            cand[i] = req_valid[i] && (state_q[i] == IDLE);
            fin[i]  = (state_q[i] == XFER) && in_beat[i] && (cnt_q[i] == '0);
        end
    end

`ifdef MC_ARB_AGE_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [AGE_W-1:0] age_q [N];
    logic [AGE_W-1:0] age_d [N];

    // Lowest-indexed urgent input reserves every free output in its mask.
    always_comb begin
        logic any;
        any    = 1'b0;
        urg_oh = '0;
        rsv    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && cand[i] && (age_q[i] == AGE_W'(AGE_MAX))) begin
                any       = 1'b1;
                urg_oh[i] = 1'b1;
                rsv       = dst[i] & ~lock_q;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            age_d[i] = age_q[i];
            if (!req_valid[i] || hs[i]) begin
                age_d[i] = '0;
            end else if (cand[i] && (age_q[i] != AGE_W'(AGE_MAX))) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign urg_oh = '0;
    assign rsv    = '0;
`endif

    always_comb begin
        for (int unsigned o = 0; o < N; o++) begin
            for (int unsigned i = 0; i < N; i++) begin
                comp_req[o][i] = cand[i] && dst[i][o] && !lock_q[o] && (!rsv[o] || urg_oh[i]);
            end
        end
    end

    for (genvar o = 0; o < N; o++) begin : g_pick
        mc_rr_pick #(.N(N)) u_pick (
            .req   (comp_req[o]),
            .ptr   (ptr_q[o]),
            .grant (win[o])
        );
    end

    // A candidate is ready only if it won every output in its mask (empty mask: vacuously).
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            req_ready[i] = cand[i];
            for (int unsigned o = 0; o < N; o++) begin
                if (dst[i][o] && !win[o][i]) req_ready[i] = 1'b0;
            end
        end
    end

    assign hs = req_valid & req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        err_d   = err_q;
        for (int unsigned i = 0; i < N; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (hs[i]) begin
                        if (|dst[i]) begin
                            state_d[i] = XFER;
                            cnt_d[i]   = req_len[i*LEN_W +: LEN_W];
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                XFER: begin
                    if (in_beat[i]) begin
                        if (cnt_q[i] == '0) state_d[i] = IDLE;
                        else                cnt_d[i]   = cnt_q[i] - LEN_W'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
        for (int unsigned o = 0; o < N; o++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (lock_q[o] && (owner_q[o] == SEL_W'(i)) && fin[i]) begin
                    lock_d[o]  = 1'b0;
                    owner_d[o] = '0;
                end
                if (hs[i] && dst[i][o]) begin
                    lock_d[o]  = 1'b1;
                    owner_d[o] = SEL_W'(i);
                    ptr_d[o]   = SEL_W'((i + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                owner_q[i] <= '0;
                ptr_q[i]   <= '0;
            end
            lock_q <= '0;
            err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            in_busy[i]                  = (state_q[i] == XFER);
            out_sel[i*SEL_W +: SEL_W]   = owner_q[i];
        end
    end

    assign out_active   = lock_q;
    assign err_zero_dst = err_q;

endmodule

// File: tb/tb_mc_lock_arbiter.sv
// Directed bench for mc_lock_arbiter (N=4, LEN_W=8, AGE_MAX=3).
module tb_mc_lock_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_dst;
    logic [31:0] req_len;
    logic [3:0]  req_ready;
    logic [3:0]  in_beat;
    logic [3:0]  in_busy;
    logic [7:0]  out_sel;
    logic [3:0]  out_active;
    logic        err_zero_dst;

    int n_checks = 0;
    int n_pass   = 0;

    mc_lock_arbiter #(.NUM_PORTS(4), .LEN_W(8), .AGE_MAX(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_dst      (req_dst),
        .req_len      (req_len),
        .req_ready    (req_ready),
        .in_beat      (in_beat),
        .in_busy      (in_busy),
        .out_sel      (out_sel),
        .out_active   (out_active),
        .err_zero_dst (err_zero_dst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] d, input logic [7:0] l);
        req_valid[i]     = v;
        req_dst[i*4 +: 4] = d;
        req_len[i*8 +: 8] = l;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_dst = '0; req_len = '0; in_beat = '0;
        tick(); tick();
        check("rst_active", 32'(out_active), 32'h0);
        check("rst_sel",    32'(out_sel),    32'h0);
        check("rst_busy",   32'(in_busy),    32'h0);
        check("rst_err",    32'(err_zero_dst), 32'h0);
        rst_n = 1'b1;
        #1;

        // Multicast lock, 3-beat transfer
        set_req(0, 1'b1, 4'b0110, 8'd2);
        #1 check("t1_ready", 32'(req_ready), 32'b0001);
        tick(); req_valid[0] = 1'b0; #1;
        check("t1_active", 32'(out_active), 32'b0110);
        check("t1_sel",    32'(out_sel),    32'h00);
        check("t1_busy",   32'(in_busy),    32'b0001);
        in_beat[0] = 1'b1;
        tick(); tick();
        check("t1_mid_active", 32'(out_active), 32'b0110);
        tick(); in_beat[0] = 1'b0; #1;
        check("t1_free_active", 32'(out_active), 32'b0000);
        check("t1_free_busy",   32'(in_busy),    32'b0000);

        // Partial win grants nothing; ptr1=1 favours input1
        set_req(0, 1'b1, 4'b0011, 8'd0);
        set_req(1, 1'b1, 4'b0010, 8'd0);
        #1 check("t2_ready", 32'(req_ready), 32'b0010);
        tick(); req_valid[1] = 1'b0; #1;
        check("t2_denied", 32'(req_ready), 32'b0000);
        check("t2_active", 32'(out_active), 32'b0010);
        check("t2_sel",    32'(out_sel),    32'h04);
        // ptr0 must still be 0, so input0 beats input3 on out0
        set_req(0, 1'b1, 4'b0001, 8'd0);
        set_req(3, 1'b1, 4'b0001, 8'd0);
        in_beat[1] = 1'b1;
        #1 check("t2_ptr0_ready", 32'(req_ready), 32'b0001);
        tick(); in_beat[1] = 1'b0; req_valid[0] = 1'b0; req_valid[3] = 1'b0; #1;
        check("t2_active2", 32'(out_active), 32'b0001);
        check("t2_sel2",    32'(out_sel),    32'h00);
        in_beat[0] = 1'b1; tick(); in_beat[0] = 1'b0; #1;
        check("t2_free", 32'(out_active), 32'b0000);

        // Disjoint grants in one cycle
        set_req(2, 1'b1, 4'b1000, 8'd1);
        set_req(3, 1'b1, 4'b0001, 8'd1);
        #1 check("t3_ready", 32'(req_ready), 32'b1100);
        tick(); req_valid[2] = 1'b0; req_valid[3] = 1'b0; #1;
        check("t3_active", 32'(out_active), 32'b1001);
        check("t3_sel",    32'(out_sel),    32'h83);
        check("t3_busy",   32'(in_busy),    32'b1100);
        in_beat = 4'b1100;
        tick();
        check("t3_mid_active", 32'(out_active), 32'b1001);
        tick(); in_beat = '0; #1;
        check("t3_free_active", 32'(out_active), 32'b0000);
        check("t3_free_busy",   32'(in_busy),    32'b0000);

        // No same-cycle reuse of a freed output
        set_req(1, 1'b1, 4'b0100, 8'd0);
        tick(); req_valid[1] = 1'b0;
        set_req(3, 1'b1, 4'b0100, 8'd0);
        #1 check("t4_blocked", 32'(req_ready), 32'b0000);
        in_beat[1] = 1'b1;
        #1 check("t4_no_reuse", 32'(req_ready), 32'b0000);
        tick(); in_beat[1] = 1'b0; #1;
        check("t4_ready", 32'(req_ready), 32'b1000);
        check("t4_freed", 32'(out_active), 32'b0000);
        tick(); req_valid[3] = 1'b0; #1;
        check("t4_active", 32'(out_active), 32'b0100);
        check("t4_sel",    32'(out_sel),    32'h30);
        in_beat[3] = 1'b1; tick(); in_beat = '0; #1;

        // Zero mask
        check("t5_err_pre", 32'(err_zero_dst), 32'h0);
        set_req(2, 1'b1, 4'b0000, 8'd0);
        #1 check("t5_ready", 32'(req_ready), 32'b0100);
        tick(); req_valid[2] = 1'b0; #1;
        check("t5_err",    32'(err_zero_dst), 32'h1);
        check("t5_active", 32'(out_active),   32'b0000);
        check("t5_busy",   32'(in_busy),      32'b0000);
        in_beat = 4'b1111; tick(); in_beat = '0; #1;
        check("t5_idle_beat", 32'(in_busy), 32'b0000);
        check("t5_err_sticky", 32'(err_zero_dst), 32'h1);

        // Asynchronous reset mid-transfer
        set_req(0, 1'b1, 4'b1111, 8'd5);
        tick(); req_valid[0] = 1'b0; #1;
        check("t6_active", 32'(out_active), 32'b1111);
        check("t6_busy",   32'(in_busy),    32'b0001);
        in_beat[0] = 1'b1; tick(); in_beat[0] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_active", 32'(out_active), 32'b0000);
        check("t6_rst_sel",    32'(out_sel),    32'h00);
        check("t6_rst_busy",   32'(in_busy),    32'b0000);
        check("t6_rst_err",    32'(err_zero_dst), 32'h0);
        tick(); rst_n = 1'b1; #1;

`ifdef MC_ARB_AGE_EN
        // Starvation guard with AGE_MAX=3
        set_req(1, 1'b1, 4'b0001, 8'd0);
        #1 check("a_setup_ready", 32'(req_ready), 32'b0010);
        tick(); req_valid[1] = 1'b0; in_beat[1] = 1'b1;
        tick(); in_beat[1] = 1'b0;
        set_req(1, 1'b1, 4'b0010, 8'd0);
        tick(); req_valid[1] = 1'b0; #1;
        check("a_lock1", 32'(out_active), 32'b0010);
        set_req(0, 1'b1, 4'b0011, 8'd0);
        tick(); tick();
        set_req(2, 1'b1, 4'b0001, 8'd0);
        #1 check("a_age2_ready", 32'(req_ready), 32'b0100);
        req_valid[2] = 1'b0;
        tick();
        req_valid[2] = 1'b1;
        #1 check("a_reserved", 32'(req_ready), 32'b0000);
        in_beat[1] = 1'b1;
        tick(); in_beat[1] = 1'b0; #1;
        check("a_urgent_ready", 32'(req_ready), 32'b0001);
        tick(); req_valid[0] = 1'b0; req_valid[2] = 1'b0; #1;
        check("a_active", 32'(out_active), 32'b0011);
        check("a_sel",    32'(out_sel),    32'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_lock_arbiter.md
Name: mc_lock_arbiter

Overview:
- Parametrised successor to the 4-port all-or-nothing crossbar arbiter. Supports N inputs × N outputs, per-output round-robin, and multicast destination masks.
- Adds output locking for multi-beat transfers: granted outputs stay owned by the winning input until its last beat.
- Sits between the input-port request logic and the crossbar mux; drives mux selects and output-active flags.

Parameters:
- NUM_PORTS, 4, number of input ports = number of output ports (2..16).
- LEN_W, 8, width of the per-request beat-count field.
- AGE_MAX, 15, starvation threshold in cycles; used only with MC_ARB_AGE_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_PORTS  input i has a pending request
- req_dst  in  NUM_PORTS*NUM_PORTS  slice [i*N +: N] is input i's destination mask (multicast allowed)
- req_len  in  NUM_PORTS*LEN_W  slice i = beats-1 (0 means 1 beat)
- req_ready  out  NUM_PORTS  combinational accept; valid&ready at a rising edge is the handshake
- in_beat  in  NUM_PORTS  input i moved one data beat this cycle
- in_busy  out  NUM_PORTS  input i is in XFER
- out_sel  out  NUM_PORTS*SEL_W  SEL_W = max(1,$clog2(N)); owning input index per output
- out_active  out  NUM_PORTS  output locked to an input
- err_zero_dst  out  1  sticky: a valid request with an all-zero mask was accepted

Behaviour:
- Reset: all pointers 0, all inputs IDLE, beat counters 0, out_sel 0, out_active 0, in_busy 0, err_zero_dst 0.
- Per-input FSM:
  - IDLE → XFER on handshake with a nonzero mask.
  - XFER → IDLE on the edge where in_beat[i]=1 and the counter is 0.
- Counter: loaded with req_len on handshake; decrements on each in_beat while in XFER. in_beat in IDLE is ignored.
- Output state: free or locked(owner). Locking happens on the handshake edge. The output is freed on the owner's final-beat edge.
- Freed outputs are arbitrable in the next cycle. There is no same-cycle reuse: req_ready is computed from registered state only.
- Arbitration (combinational, from registered state):
  - Candidates are inputs with valid=1 and state IDLE.
  - Per output o, only candidates with req_dst[o]=1 compete, and only while o is free.
  - Winner is the first candidate at or after ptr[o], wrapping modulo NUM_PORTS (explicit wrap for non-power-of-two N).
- Grant (all-or-nothing): req_ready[i]=1 iff i is a candidate and has won every output in its mask. A partial win grants nothing; those outputs stay free this cycle.
- Pointer update: only on handshake, ptr[o] ← (owner+1) mod N for each output locked that edge. Denied wins do not rotate the pointer.
- Zero mask: req_ready=1 immediately, no lock, input stays IDLE, err_zero_dst set. It clears only on reset.
- Multiple inputs may be granted in the same cycle if their masks are disjoint.
- in_busy[i] = state XFER.
- out_sel holds the owner during a lock and reads 0 when free. out_active mirrors the lock bit.
- Latency: lock visible on out_active/out_sel one cycle after the handshake. A 1-beat transfer frees the output after its single in_beat edge.
- Reset mid-transfer: all locks dropped and pointers cleared immediately (asynchronously).
- Deasserting req_valid without a handshake is legal; no state changes.

Optional Feature:
- MC_ARB_AGE_EN defined:
  - Per-input saturating age counter (width $clog2(AGE_MAX+1)). It increments each cycle the input is a candidate without a handshake, and clears on handshake or when valid=0.
  - At age==AGE_MAX the input is urgent. The lowest-indexed urgent input reserves every free output in its mask: no other input can win those outputs until it is granted.
  - Outputs outside the reserved set arbitrate normally.
- Not defined: pure round-robin; no age logic synthesised; AGE_MAX ignored.

Decomposition:
- Package mc_arb_pkg: state enum (IDLE, XFER), SEL_W computation function, maximum-ports constant.
- Sub-module mc_rr_pick: N-way one-hot round-robin picker (req vector, ptr → one-hot winner), instantiated once per output.

Test Plan:
- N=4: input0 dst=0110 len=2, others idle → req_ready[0]=1 at cycle 0. out_active=0110 and out_sel1=out_sel2=0 from cycle 1. After 3 in_beat edges out_active=0000. ptr1=ptr2=1.
- Input0 dst=0011, input1 dst=0010, ptr1=1, ptr0=0 → input0 wins out0 but loses out1, so no grant to input0. Input1 is granted. ptr0 unchanged; ptr1→2.
- Disjoint multicast: input2 dst=1000 and input3 dst=0001 in the same cycle → both ready, both locked; ptr3→3, ptr0→0.
- Input1 locks out2 len=0, input3 requests out2 → input3 is granted only in the cycle after input1's single in_beat, never in the same cycle.
- Zero mask: valid with dst=0000 → ready=1, err_zero_dst=1, no out_active change.
- With MC_ARB_AGE_EN, AGE_MAX=3: input0 dst=0011 repeatedly denied by alternating 0001/0010 traffic → after 3 denied cycles, outputs 0 and 1 are reserved and input0 is granted once both are free. Reset asserted mid-XFER → all outputs 0 immediately.
